npu_host_seq: RTL and testbench

Bus-initiator sequencer that drives the NPU's memory-mapped host port (ena/wea/addra/dina/douta). It is the master end of that interface.
- Accepts a command stream (WRITE, READ, POLL) over a valid/ready channel.
- Issues single-cycle bus strobes for each command.
- Returns read data and status over a valid/ready response channel.
- Replaces software bit-banging for image/weight loading, layer triggering and done polling.

---
 rtl/npu_host_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_npu_host_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_host_seq.sv
// npu_host_seq: bus-initiator sequencer for the NPU host port.
// Accepts WRITE/READ/POLL commands over a valid/ready channel, issues
// single-cycle ena/wea strobes, and returns read data and status on a
// valid/ready response channel.
// Optional build macro NPU_SEQ_STATS_EN adds saturating strobe/retry counters.
module npu_host_seq #(
  parameter int READ_LAT = 1,
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [31:0]       cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              ena,
  output logic              wea,
  output logic [15:0]       addra,
  output logic [31:0]       dina,
  input  logic [31:0]       douta
`ifdef NPU_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_wr,
  output logic [CNT_W-1:0]  stat_rd,
  output logic [CNT_W-1:0]  stat_poll_retry
`endif
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE, WR, RD, RD_WAIT, CHECK, GAP, RSP
  } state_e;

  state_e             state_q;
  op_e                op_q;
  logic [31:0]        data_q;
  logic [31:0]        mask_q;
  logic [CNT_W-1:0]   attempts_q;
  logic [LAT_W-1:0]   lat_q;
  logic [GAP_W-1:0]   gap_q;
  logic               cmd_ready_q;
  logic               ena_q;
  logic               wea_q;
  logic [15:0]        addra_q;
  logic [31:0]        dina_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_err_q;
  logic               poll_miss;

  // Poll compare runs on the value captured at the end of RD_WAIT.
  assign poll_miss = ((rsp_data_q ^ data_q) & mask_q) != 32'h0;

  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != IDLE);
  assign ena       = ena_q;
  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Main sequencer: state, bus strobes and response registers move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_WR;
      data_q      <= '0;
      mask_q      <= '0;
      attempts_q  <= '0;
      lat_q       <= '0;
      gap_q       <= '0;
      cmd_ready_q <= 1'b0;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the entering transition raises them.
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            op_q        <= op_e'(cmd_op);
            data_q      <= cmd_data;
            mask_q      <= cmd_mask;
            attempts_q  <= '0;
            case (op_e'(cmd_op))
              OP_WR: begin
                state_q <= WR;
                ena_q   <= 1'b1;
                wea_q   <= 1'b1;
                addra_q <= cmd_addr;
                dina_q  <= cmd_data;
              end
              OP_RD, OP_POLL: begin
                state_q <= RD;
                ena_q   <= 1'b1;
                addra_q <= cmd_addr;
              end
              default: begin
                state_q     <= RSP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end
        WR: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        RD: begin
          state_q <= RD_WAIT;
          lat_q   <= '0;
        end
        RD_WAIT: begin
          if (lat_q == LAT_W'(READ_LAT - 1)) begin
            rsp_data_q <= douta;
            if (op_q == OP_POLL) begin
              state_q <= CHECK;
            end else begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
            end
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        CHECK: begin
          if (!poll_miss) begin
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end else begin
            attempts_q <= attempts_q + CNT_W'(1);
            if (attempts_q + CNT_W'(1) == CNT_W'(POLL_MAX)) begin
              // Timeout: report the last value read with the error flag.
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (POLL_GAP == 0) begin
              state_q <= RD;
              ena_q   <= 1'b1;
            end else begin
              state_q <= GAP;
              gap_q   <= '0;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(POLL_GAP - 1)) begin
            state_q <= RD;
            ena_q   <= 1'b1;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NPU_SEQ_STATS_EN
  logic [CNT_W-1:0] stat_wr_q, stat_rd_q, stat_retry_q;

  assign stat_wr         = stat_wr_q;
  assign stat_rd         = stat_rd_q;
  assign stat_poll_retry = stat_retry_q;

  // Saturating counters keyed off the strobe cycles and failed poll compares.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_q    <= '0;
      stat_rd_q    <= '0;
      stat_retry_q <= '0;
    end else begin
      if (state_q == WR && stat_wr_q != '1)
        stat_wr_q <= stat_wr_q + CNT_W'(1);
      if (state_q == RD && stat_rd_q != '1)
        stat_rd_q <= stat_rd_q + CNT_W'(1);
      if (state_q == CHECK && poll_miss && stat_retry_q != '1)
        stat_retry_q <= stat_retry_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_npu_host_seq.sv
// Directed bench for npu_host_seq: a vector table of single commands plus
// hand-written sequences for polling, response back-pressure, POLL timeout
// (second instance with POLL_MAX=4) and reset during a poll gap.
module tb_npu_host_seq;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy, ena, wea;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr, addra;
  logic [31:0] cmd_data, cmd_mask, rsp_data, dina, douta;

  // Instance B: POLL_MAX=4, douta stuck at zero.
  logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b, ena_b, wea_b;
  logic [1:0]  cmd_op_b;
  logic [15:0] cmd_addr_b, addra_b;
  logic [31:0] cmd_data_b, cmd_mask_b, rsp_data_b, dina_b, douta_b;

`ifdef NPU_SEQ_STATS_EN
  logic [15:0] stat_wr, stat_rd, stat_retry, stat_wr_b, stat_rd_b, stat_retry_b;
`endif

  npu_host_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
`ifdef NPU_SEQ_STATS_EN
    , .stat_wr(stat_wr), .stat_rd(stat_rd), .stat_poll_retry(stat_retry)
`endif
  );

  npu_host_seq #(.POLL_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op_b),
    .cmd_addr(cmd_addr_b), .cmd_data(cmd_data_b), .cmd_mask(cmd_mask_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
    .busy(busy_b), .ena(ena_b), .wea(wea_b), .addra(addra_b), .dina(dina_b), .douta(douta_b)
`ifdef NPU_SEQ_STATS_EN
    , .stat_wr(stat_wr_b), .stat_rd(stat_rd_b), .stat_poll_retry(stat_retry_b)
`endif
  );

  // NPU read model: registered douta, first fail_n reads after rd_base return fail_val.
  int          npu_rd_n = 0;
  int          rd_base  = 0;
  int          fail_n   = 0;
  logic [31:0] fail_val = '0;
  logic [31:0] ok_val   = '0;
  initial douta = '0;
  always @(posedge clk) begin
    if (ena && !wea) begin
      douta    <= ((npu_rd_n - rd_base) < fail_n) ? fail_val : ok_val;
      npu_rd_n <= npu_rd_n + 1;
    end
  end

  // Bus monitor, sampled on the falling edge.
  int          cyc = 0;
  int          wr_n = 0, rd_n = 0, rd_b_n = 0, viol_n = 0;
  logic [15:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [31:0] last_wr_data = '0;
  int          rd_times[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wea && !ena) viol_n++;
    if (wea_b && !ena_b) viol_n++;
    if (ena && wea) begin wr_n++; last_wr_addr = addra; last_wr_data = dina; end
    if (ena && !wea) begin rd_n++; last_rd_addr = addra; rd_times.push_back(cyc); end
    if (ena_b && !wea_b) rd_b_n++;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command on instance A and wait for a response or return to idle.
  // Called and returns on a falling edge.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d,
                         input logic [31:0] m, output logic got, output logic [31:0] rd,
                         output logic er);
    int t;
    got = 1'b0; rd = '0; er = 1'b0;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!rsp_valid && !(cmd_ready && !busy) && t < 100) begin @(negedge clk); t++; end
    chk("cmd_complete_in_time", (t < 100), 1);
    if (rsp_valid) begin got = 1'b1; rd = rsp_data; er = rsp_err; end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] rdv;
    logic        exp_rsp;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  vec_t vt[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        got, er;
    logic [31:0] rd;
    int          w0, r0, n0, t, rv_seen;

    vt[0] = '{2'b00, 16'h1000, 32'h04030201, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1, 0};
    vt[1] = '{2'b01, 16'h7004, 32'h0,        32'h0,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFE, 1'b0, 0, 1};
    vt[2] = '{2'b11, 16'h5555, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1, 0, 0};
    vt[3] = '{2'b10, 16'h7010, 32'h00001200, 32'h0000FF00, 32'h00001234, 1'b1, 32'h00001234, 1'b0, 0, 1};
    vt[4] = '{2'b00, 16'hFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1, 0};
    vt[5] = '{2'b01, 16'h0000, 32'h0,        32'h0,        32'h00000000, 1'b1, 32'h00000000, 1'b0, 0, 1};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b1;
    cmd_valid_b = 1'b0; cmd_op_b = '0; cmd_addr_b = '0; cmd_data_b = '0; cmd_mask_b = '0;
    rsp_ready_b = 1'b1; douta_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ena", ena, 0);
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Vector table: one command each, constant read data
    for (int i = 0; i < 6; i++) begin
      fail_n = 0; ok_val = vt[i].rdv; rd_base = npu_rd_n;
      w0 = wr_n; r0 = rd_n;
      run_cmd(vt[i].op, vt[i].addr, vt[i].data, vt[i].mask, got, rd, er);
      #1;
      chk($sformatf("v%0d_rsp_present", i), got, vt[i].exp_rsp);
      if (vt[i].exp_rsp) begin
        chk($sformatf("v%0d_rsp_data", i), rd, vt[i].exp_data);
        chk($sformatf("v%0d_rsp_err", i), er, vt[i].exp_err);
      end
      chk($sformatf("v%0d_wr_strobes", i), wr_n - w0, vt[i].exp_wr);
      chk($sformatf("v%0d_rd_strobes", i), rd_n - r0, vt[i].exp_rd);
      if (vt[i].exp_wr == 1) begin
        chk($sformatf("v%0d_wr_addr", i), last_wr_addr, vt[i].addr);
        chk($sformatf("v%0d_wr_data", i), last_wr_data, vt[i].data);
      end
      if (vt[i].exp_rd == 1)
        chk($sformatf("v%0d_rd_addr", i), last_rd_addr, vt[i].addr);
      @(negedge clk);
    end

    // POLL succeeding on the 5th read; strobes every 4 cycles (RD, RD_WAIT, CHECK, GAP)
    fail_n = 4; fail_val = 32'h0; ok_val = 32'h1; rd_base = npu_rd_n;
    r0 = rd_n; n0 = rd_times.size();
    run_cmd(2'b10, 16'h7000, 32'h1, 32'h1, got, rd, er);
    #1;
    chk("poll5_rsp", got, 1);
    chk("poll5_data", rd, 32'h1);
    chk("poll5_err", er, 0);
    chk("poll5_strobes", rd_n - r0, 5);
    for (int i = n0 + 1; i < rd_times.size(); i++)
      chk("poll5_strobe_spacing", rd_times[i] - rd_times[i-1], 4);
    @(negedge clk);

    // READ with rsp_ready low for 3 cycles, a WRITE pending behind it
    fail_n = 0; ok_val = 32'hCAFEF00D; rd_base = npu_rd_n;
    rsp_ready = 1'b0;
    r0 = rd_n;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 16'h7008;
    @(negedge clk);
    cmd_op = 2'b00; cmd_addr = 16'h2000; cmd_data = 32'h12345678;
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk("bp_rsp_in_time", (t < 100), 1);
    w0 = wr_n;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid_held", rsp_valid, 1);
      chk("bp_rsp_data_held", rsp_data, 32'hCAFEF00D);
      chk("bp_cmd_ready_low", cmd_ready, 0);
      chk("bp_no_bus", ena, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_valid_dropped", rsp_valid, 0);
    chk("bp_cmd_ready_back", cmd_ready, 1);
    chk("bp_no_wr_before_hs", wr_n - w0, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_wr_ena", ena, 1);
    chk("bp_wr_wea", wea, 1);
    chk("bp_wr_addr", addra, 16'h2000);
    chk("bp_wr_data", dina, 32'h12345678);
    chk("bp_rd_strobes", rd_n - r0, 1);
    @(negedge clk);
    chk("bp_wr_single_cycle", ena, 0);

    // POLL timeout on instance B (POLL_MAX=4, douta stuck at 0)
    r0 = rd_b_n;
    chk("b_cmd_ready", cmd_ready_b, 1);
    cmd_valid_b = 1'b1; cmd_op_b = 2'b10; cmd_addr_b = 16'h7000;
    cmd_data_b = 32'h1; cmd_mask_b = 32'h1;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    t = 0;
    while (!rsp_valid_b && t < 200) begin @(negedge clk); t++; end
    chk("b_rsp_in_time", (t < 200), 1);
    chk("b_timeout_err", rsp_err_b, 1);
    chk("b_timeout_data", rsp_data_b, 32'h0);
    chk("b_timeout_strobes", rd_b_n - r0, 4);
`ifdef NPU_SEQ_STATS_EN
    chk("b_stat_retry", stat_retry_b, 4);
    chk("b_stat_rd", stat_rd_b, 4);
`endif
    @(negedge clk);
    chk("b_rsp_consumed", rsp_valid_b, 0);

    // Reset asserted during the GAP of a POLL
    fail_n = 1000; fail_val = 32'h0; ok_val = 32'h1; rd_base = npu_rd_n;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 16'h7000; cmd_data = 32'h1; cmd_mask = 32'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rg_poll_strobe", ena, 1);
    repeat (3) @(negedge clk);
    chk("rg_in_gap_busy", busy, 1);
    chk("rg_in_gap_no_rsp", rsp_valid, 0);
    #2 rst = 1'b1;
    #1;
    chk("rg_rst_ena", ena, 0);
    chk("rg_rst_wea", wea, 0);
    chk("rg_rst_busy", busy, 0);
    chk("rg_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    chk("rg_no_rsp_after_rst", rv_seen, 0);
    chk("rg_cmd_ready_after_rst", cmd_ready, 1);
    w0 = wr_n; r0 = rd_n;
    run_cmd(2'b00, 16'h3000, 32'h55AA55AA, 32'h0, got, rd, er);
    #1;
    chk("rg_wr_no_rsp", got, 0);
    chk("rg_wr_strobes", wr_n - w0, 1);
    chk("rg_rd_strobes", rd_n - r0, 0);
    chk("rg_wr_addr", last_wr_addr, 16'h3000);
    chk("rg_wr_data", last_wr_data, 32'h55AA55AA);

    chk("wea_without_ena", viol_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
